// File: rtl/pool_pkg.sv
// Shared types and width helpers for the 2x2 stride-2 streaming pool.
package pool_pkg;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } pool_state_e;

  // Width of a partial/full window sum: four DATA_W samples never overflow DATA_W+2 bits.
  function automatic int unsigned psum_w(input int unsigned data_w);
    return data_w + 2;
  endfunction

  // Index width for a counter over n entries, at least one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool2x2_stream_if.sv
// Valid/ready stream carrying CH packed signed lanes of DATA_W bits.
interface pool2x2_stream_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 1
);
  logic                   valid;
  logic                   ready;
  logic [CH*DATA_W-1:0]   data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pool2x2_lane.sv
// One channel of the 2x2 pool: horizontal hold register, one-row line buffer of pair
// partials, and the final combine producing the pooled sample for the current window.
module pool2x2_lane
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FM_W   = 6,
  localparam int unsigned ColW  = idx_w(FM_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     accept_i,
  input  logic                     row_odd_i,
  input  logic [ColW-1:0]          col_i,
  input  pool_mode_e               mode_i,
  input  logic signed [DATA_W-1:0] px_i,
  output logic signed [DATA_W-1:0] result_o
);

  localparam int unsigned PW     = psum_w(DATA_W);
  localparam int unsigned LbD    = FM_W / 2;
  localparam int unsigned LbIdxW = idx_w(LbD);

  typedef logic signed [PW-1:0] psum_t;

  function automatic psum_t combine(input psum_t a, input psum_t b, input pool_mode_e m);
    if (m == POOL_MAX) return (a > b) ? a : b;
    return a + b;
  endfunction

  psum_t             px_ext;
  psum_t             pair;
  psum_t             full;
  psum_t             full_shr;
  psum_t             hold_q, hold_d;
  psum_t             lb_q [LbD];
  psum_t             lb_d [LbD];
  logic [LbIdxW-1:0] lb_idx;

  assign px_ext   = {{(PW - DATA_W){px_i[DATA_W-1]}}, px_i};
  assign lb_idx   = LbIdxW'(col_i >> 1);
  assign pair     = combine(hold_q, px_ext, mode_i);
  assign full     = combine(lb_q[lb_idx], pair, mode_i);
  // Arithmetic shift floors toward -inf; the quotient always fits back into DATA_W.
  assign full_shr = full >>> 2;
  assign result_o = (mode_i == POOL_MAX) ? full[DATA_W-1:0] : full_shr[DATA_W-1:0];

  // Next-state: even column loads hold, odd column on an even row stores the pair partial.
  always_comb begin
    hold_d = hold_q;
    lb_d   = lb_q;
    if (accept_i) begin
      if (!col_i[0]) begin
        hold_d = px_ext;
      end else if (!row_odd_i) begin
        lb_d[lb_idx] = pair;
      end
    end
  end

  // Hold register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Line buffer is always written on an even row before being read on the odd row: no reset.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

endmodule

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 average-or-max pooling over a raster feature map, CH lanes wide.
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FM_W   = 6,
  parameter int unsigned FM_H   = 6,
  parameter int unsigned CH     = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  pool2x2_stream_if.slave        in_if,
  pool2x2_stream_if.master       out_if,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned ColW = idx_w(FM_W);
  localparam int unsigned RowW = idx_w(FM_H);

  if ((FM_W % 2) != 0 || (FM_H % 2) != 0 || FM_W < 2 || FM_H < 2) begin : g_bad_dims
    $error("pool2x2_stream: FM_W and FM_H must be even and >= 2");
  end

  pool_state_e          state_q, state_d;
  pool_mode_e           mode_q, mode_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  logic                 out_valid_q, out_valid_d;
  logic [CH*DATA_W-1:0] out_data_q, out_data_d;
  logic [CH*DATA_W-1:0] lane_res;
  logic                 in_ready;
  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic                 emit;

  assign in_ready = (state_q == StRun) && (!out_valid_q || out_if.ready);
  assign accept   = in_if.valid && in_ready;
  assign last_col = (col_q == ColW'(FM_W - 1));
  assign last_row = (row_q == RowW'(FM_H - 1));
  assign emit     = accept && row_q[0] && col_q[0];

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid_q;
  assign out_if.data  = out_data_q;
  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign done         = (state_q == StDone);

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool2x2_lane #(
      .DATA_W (DATA_W),
      .FM_W   (FM_W)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept_i  (accept),
      .row_odd_i (row_q[0]),
      .col_i     (col_q),
      .mode_i    (mode_q),
      .px_i      (in_if.data[k*DATA_W +: DATA_W]),
      .result_o  (lane_res[k*DATA_W +: DATA_W])
    );
  end

  // Frame FSM, raster counters and registered output beat.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          mode_d  = pool_mode_e'(mode);
          col_d   = '0;
          row_d   = '0;
        end
      end
      StRun: begin
        if (out_valid_q && out_if.ready) out_valid_d = 1'b0;
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_res;
          end
          if (last_col && last_row) state_d = StDrain;
        end
      end
      StDrain: begin
        // Last window is pending in the output register; finish once it is taken.
        if (out_if.ready) begin
          out_valid_d = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= POOL_AVG;
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench: 6x6 single-lane instance and 8x4 four-lane instance.
module tb_pool2x2_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, mode_a, busy_a, done_a;
  logic start_b, mode_b, busy_b, done_b;

  pool2x2_stream_if #(.DATA_W(8), .CH(1)) a_in ();
  pool2x2_stream_if #(.DATA_W(8), .CH(1)) a_out ();
  pool2x2_stream_if #(.DATA_W(8), .CH(4)) b_in ();
  pool2x2_stream_if #(.DATA_W(8), .CH(4)) b_out ();

  pool2x2_stream #(.DATA_W(8), .FM_W(6), .FM_H(6), .CH(1)) u_dut_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_a),
    .mode   (mode_a),
    .in_if  (a_in),
    .out_if (a_out),
    .busy   (busy_a),
    .done   (done_a)
  );

  pool2x2_stream #(.DATA_W(8), .FM_W(8), .FM_H(4), .CH(4)) u_dut_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_b),
    .mode   (mode_b),
    .in_if  (b_in),
    .out_if (b_out),
    .busy   (busy_b),
    .done   (done_b)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic signed [7:0] pix_a [36];
  logic [7:0]        got_a [16];
  int                exp_a [9];
  int                nout_a, ndone_a, nstall_a, nready_a, nidle_a;
  logic              start_mid_a;

  logic [31:0]       got_b [16];
  int                nout_b, ndone_b;

  // Drive one 6x6 frame into DUT A, capture pooled beats and protocol violations.
  task automatic run_frame_a(input logic md, input int ready_pct);
    int idx, cyc;
    logic acc_in, acc_out, stalled_prev;
    logic [7:0] data_prev;
    nout_a = 0; ndone_a = 0; nstall_a = 0; nready_a = 0; nidle_a = 0;
    idx = 0; cyc = 0; stalled_prev = 1'b0; data_prev = '0;
    @(negedge clk);
    mode_a = md; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; mode_a = ~md;
    while (ndone_a == 0 && cyc < 2000) begin
      a_out.ready = (int'($urandom_range(99)) < ready_pct);
      a_in.valid  = (idx < 36);
      a_in.data   = (idx < 36) ? pix_a[idx] : 8'h00;
      start_a     = start_mid_a && (idx == 10);
      #1;
      acc_in  = a_in.valid && a_in.ready;
      acc_out = a_out.valid && a_out.ready;
      if (stalled_prev && (!a_out.valid || a_out.data !== data_prev)) nstall_a++;
      if (a_out.valid && !a_out.ready && a_in.ready) nready_a++;
      if (done_a) ndone_a++;
      if (acc_out) begin
        if (nout_a < 16) got_a[nout_a] = a_out.data;
        nout_a++;
      end
      stalled_prev = a_out.valid && !a_out.ready;
      data_prev    = a_out.data;
      @(posedge clk);
      if (acc_in) idx++;
      @(negedge clk);
      cyc++;
    end
    if (ndone_a == 0) $display("FAIL frame_a timeout: got no done after %0d cycles, want done", cyc);
    start_a = 1'b0; a_in.valid = 1'b1; a_in.data = 8'h55; a_out.ready = 1'b1;
    repeat (4) begin
      #1;
      if (done_a) ndone_a++;
      if (a_in.ready) nidle_a++;
      if (a_out.valid) nout_a++;
      @(negedge clk);
    end
    a_in.valid = 1'b0;
  endtask

  // Drive one 8x4 four-lane frame into DUT B with distinct per-lane ramps.
  task automatic run_frame_b(input logic md);
    int idx, cyc;
    logic acc_in, acc_out;
    nout_b = 0; ndone_b = 0; idx = 0; cyc = 0;
    @(negedge clk);
    mode_b = md; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    while (ndone_b == 0 && cyc < 500) begin
      b_out.ready = 1'b1;
      b_in.valid  = (idx < 32);
      b_in.data   = {8'(2 * idx - 40), 8'(100 - 3 * idx), 8'(-idx), 8'(idx)};
      #1;
      acc_in  = b_in.valid && b_in.ready;
      acc_out = b_out.valid && b_out.ready;
      if (done_b) ndone_b++;
      if (acc_out) begin
        if (nout_b < 16) got_b[nout_b] = b_out.data;
        nout_b++;
      end
      @(posedge clk);
      if (acc_in) idx++;
      @(negedge clk);
      cyc++;
    end
    if (ndone_b == 0) $display("FAIL frame_b timeout: got no done after %0d cycles, want done", cyc);
    b_in.valid = 1'b0;
  endtask

  task automatic set_window(input int w, input int p00, input int p01, input int p10,
                            input int p11);
    int base;
    base = 2 * (w / 3) * 6 + 2 * (w % 3);
    pix_a[base]     = 8'(p00);
    pix_a[base + 1] = 8'(p01);
    pix_a[base + 6] = 8'(p10);
    pix_a[base + 7] = 8'(p11);
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({a_in.ready, a_out.valid, busy_a, done_a} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl_a: got %b want 0000", {a_in.ready, a_out.valid, busy_a, done_a});
    end
    tests_run++;
    if (a_out.data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data_a: got %h want 00", a_out.data);
    end
    tests_run++;
    if ({b_in.ready, b_out.valid, busy_b, done_b} !== 4'b0000 || b_out.data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_b: got ctrl %b data %h want 0", {b_in.ready, b_out.valid, busy_b,
               done_b}, b_out.data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_in.valid = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (a_in.ready !== 1'b0 || busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_accept: got ready %b busy %b want 0 0", a_in.ready, busy_a);
    end
    a_in.valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_avg();
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(i);
    exp_a = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
    start_mid_a = 1'b0;
    run_frame_a(1'b0, 100);
    tests_run++;
    if (nout_a !== 9 || ndone_a !== 1 || nidle_a !== 0) begin
      tests_failed++;
      $display("FAIL avg_counts: got beats %0d done %0d idle_acc %0d want 9 1 0", nout_a,
               ndone_a, nidle_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL avg_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(i);
    exp_a = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    run_frame_a(1'b1, 100);
    tests_run++;
    if (nout_a !== 9 || ndone_a !== 1) begin
      tests_failed++;
      $display("FAIL max_counts: got beats %0d done %0d want 9 1", nout_a, ndone_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL max_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  task automatic test_negated();
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(-i);
    exp_a = '{-4, -6, -8, -16, -18, -20, -28, -30, -32};
    run_frame_a(1'b0, 100);
    tests_run++;
    if (nout_a !== 9 || ndone_a !== 1) begin
      tests_failed++;
      $display("FAIL neg_counts: got beats %0d done %0d want 9 1", nout_a, ndone_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL neg_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(0);
    set_window(0, -128, -128, -128, -128);
    set_window(1, 127, 127, 127, 127);
    set_window(2, 127, 127, -128, -128);
    set_window(3, -1, -2, -7, -8);
    exp_a = '{-128, 127, -1, -5, 0, 0, 0, 0, 0};
    run_frame_a(1'b0, 100);
    tests_run++;
    if (nout_a !== 9) begin
      tests_failed++;
      $display("FAIL ext_avg_count: got %0d want 9", nout_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL ext_avg_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
    exp_a = '{-128, 127, 127, -1, 0, 0, 0, 0, 0};
    run_frame_a(1'b1, 100);
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL ext_max_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(i);
    exp_a = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
    run_frame_a(1'b0, 30);
    tests_run++;
    if (nout_a !== 9 || ndone_a !== 1) begin
      tests_failed++;
      $display("FAIL bp_counts: got beats %0d done %0d want 9 1", nout_a, ndone_a);
    end
    tests_run++;
    if (nstall_a !== 0) begin
      tests_failed++;
      $display("FAIL bp_stable: got %0d unstable stalled beats want 0", nstall_a);
    end
    tests_run++;
    if (nready_a !== 0) begin
      tests_failed++;
      $display("FAIL bp_in_ready: got %0d cycles in_ready=1 while stalled want 0", nready_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  task automatic test_multilane();
    int exp_b [4][8];
    exp_b[0] = '{9, 11, 13, 15, 25, 27, 29, 31};
    exp_b[1] = '{0, -2, -4, -6, -16, -18, -20, -22};
    exp_b[2] = '{100, 94, 88, 82, 52, 46, 40, 34};
    exp_b[3] = '{-22, -18, -14, -10, 10, 14, 18, 22};
    run_frame_b(1'b1);
    tests_run++;
    if (nout_b !== 8 || ndone_b !== 1) begin
      tests_failed++;
      $display("FAIL ml_counts: got beats %0d done %0d want 8 1", nout_b, ndone_b);
    end
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] w;
        w = got_b[j];
        tests_run++;
        if (int'($signed(w[k*8 +: 8])) !== exp_b[k][j]) begin
          tests_failed++;
          $display("FAIL ml_beat%0d_lane%0d: got %0d want %0d", j, k, $signed(w[k*8 +: 8]),
                   exp_b[k][j]);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(i);
    exp_a = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
    start_mid_a = 1'b1;
    run_frame_a(1'b0, 100);
    start_mid_a = 1'b0;
    tests_run++;
    if (nout_a !== 9 || ndone_a !== 1) begin
      tests_failed++;
      $display("FAIL srun_counts: got beats %0d done %0d want 9 1", nout_a, ndone_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL srun_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  task automatic test_abort();
    int idx, cyc;
    logic acc;
    for (int i = 0; i < 36; i++) pix_a[i] = 8'(i);
    @(negedge clk);
    mode_a = 1'b0; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    idx = 0; cyc = 0;
    // Twenty beats with a free output, then stall until the next window is pending.
    while ((idx < 20 || !a_out.valid) && cyc < 200) begin
      a_out.ready = (idx < 20);
      a_in.valid  = 1'b1;
      a_in.data   = pix_a[idx];
      #1;
      acc = a_in.valid && a_in.ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      cyc++;
    end
    a_in.valid = 1'b0;
    #1;
    tests_run++;
    if (a_out.valid !== 1'b1 || busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: got valid %b busy %b want 1 1", a_out.valid, busy_a);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_in.ready, a_out.valid, busy_a, done_a} !== 4'b0000 || a_out.data !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_outputs: got ctrl %b data %h want 0000 00",
               {a_in.ready, a_out.valid, busy_a, done_a}, a_out.data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_a = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
    run_frame_a(1'b0, 100);
    tests_run++;
    if (nout_a !== 9 || ndone_a !== 1) begin
      tests_failed++;
      $display("FAIL abort_counts: got beats %0d done %0d want 9 1", nout_a, ndone_a);
    end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (int'($signed(got_a[i])) !== exp_a[i]) begin
        tests_failed++;
        $display("FAIL abort_beat%0d: got %0d want %0d", i, $signed(got_a[i]), exp_a[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; mode_a = 1'b0; a_in.valid = 1'b0; a_in.data = '0; a_out.ready = 1'b0;
    start_b = 1'b0; mode_b = 1'b0; b_in.valid = 1'b0; b_in.data = '0; b_out.ready = 1'b0;
    start_mid_a = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_avg();
    test_max();
    test_negated();
    test_extremes();
    test_backpressure();
    test_multilane();
    test_start_ignored();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
